dual_port_ram_hs: RTL and testbench
===================================

# dual_port_ram_hs

True dual-port synchronous RAM with an independent valid/ready request channel per port (A and B), both ports on one shared clock. It is the storage block the dual-port RAM verification environment exercises through two `ram_if` agents, one per port. Each port reads or writes one word per accepted request. Same-address write collisions are resolved deterministically in favour of port A.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 6: address width; depth = 2**ADDR_WIDTH (64 words).

Ports:
- `clk`  in  1  single clock shared by both ports; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr_a` / `addr_b`  in  ADDR_WIDTH  request address, port A / B.
- `data_a` / `data_b`  in  DATA_WIDTH  write data, port A / B.
- `we_a` / `we_b`  in  1  1 = write, 0 = read; sampled with valid.
- `valid_a` / `valid_b`  in  1  request present.
- `ready_a` / `ready_b`  out  1  port can accept a request this cycle.
- `q_a` / `q_b`  out  DATA_WIDTH  registered read data.

## Operation
- A request is accepted on a rising edge where `valid_x && ready_x`. Otherwise addr, data and we are ignored.
- Accepted write: `mem[addr_x] <= data_x`. `q_x` is unchanged.
- Accepted read: `q_x <= mem[addr_x]`. `q_x` holds its value until the next accepted read on that port.
- `ready_a` = `rdy_q`.
- `ready_b` = `rdy_q && !(valid_a && we_a && valid_b && we_b && addr_a == addr_b)`.
- `rdy_q` is a flop: cleared by reset, set to 1 on the first rising edge after `rst_n` deasserts.
- `ready_b` is a combinational function of the port A/B inputs. Upstream must not make `valid` depend on `ready`.
- Same-address write/write collision: port A write is accepted. Port B stalls (`ready_b`=0) and must hold its request. It is accepted next cycle if the collision has cleared.
- Different-address writes on both ports in the same cycle: both are accepted.
- Read on one port and write on the other, same address, same cycle: both are accepted. Read data returned is governed by Configuration.
- Reads on both ports to the same address in the same cycle: both are accepted and return the same word.
- Memory array is not reset. Contents persist across reset and are undefined (X) until first written.

## Timing
- Reset (`rst_n`=0, asynchronous): `q_a`=`q_b`=0, `ready_a`=`ready_b`=0, `rdy_q`=0. No memory writes occur.
- Reset asserted mid-operation: requests in that cycle are dropped. Outputs go to reset values immediately, without waiting for a clock edge.
- First rising edge after deassert: `rdy_q`→1. Requests are accepted from the second edge onward.
- Read latency: 1 cycle. `q_x` is valid immediately after the accepting edge.
- Write latency: 1 cycle. A read accepted on the edge after the write's edge returns the new data.
- Throughput: 1 request per port per cycle, except during collision stalls on B.

## Configuration
- `DPRAM_WRITE_FIRST_EN` defined: a same-cycle same-address read on one port and write on the other returns the newly written data (write-first forwarding).
- `DPRAM_WRITE_FIRST_EN` undefined: the read returns the old memory contents (read-first).
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles. Required: `q_a`=`q_b`=0 and `ready_a`=`ready_b`=0 throughout. Both ready signals = 1 one edge after release.
- Port A write then read: write 0xA5 @0x10, then read 0x10 on A. Required: `q_a`=0xA5 after the read's edge; `q_a` unchanged across the write.
- Cross-port: write 0x3C @0x3F via A, then read 0x3F via B the next cycle. Required: `q_b`=0x3C. Repeat with roles swapped and 0xC3.
- Write/write collision: both ports write @0x05 (A=0x11, B=0x22) in the same cycle. Required: `ready_b`=0 that cycle; mem=0x11 after the edge; B accepted next cycle; a later read returns 0x22.
- Read/write same address: mem[0x20]=0x55; A writes 0x66 @0x20 while B reads 0x20 in the same cycle. Required: `q_b`=0x66 with `DPRAM_WRITE_FIRST_EN`, 0x55 without.
- Async reset mid-burst: assert `rst_n` between edges during back-to-back reads. Required: `q_a`/`q_b`/ready go to 0 immediately; data written before reset is still readable afterwards.

Source files
------------

// File: rtl/dual_port_ram_hs_if.sv
// Request channel for one port of dual_port_ram_hs: valid/ready handshake,
// address, write data, write enable and the registered read data return.
// The master modport is the requester side; the slave modport is the RAM side.
interface dual_port_ram_hs_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  we;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output addr,
        output data,
        output we,
        output valid,
        input  ready,
        input  q
    );

    modport slave (
        input  addr,
        input  data,
        input  we,
        input  valid,
        output ready,
        output q
    );
endinterface

// File: rtl/dual_port_ram_hs.sv
// dual_port_ram_hs: true dual-port synchronous RAM, one shared clock, with an
// independent valid/ready request channel per port. Each accepted request
// reads or writes one word. A same-address write/write collision is resolved
// in favour of port A: port B is stalled (ready_b low) until it clears.
//
// Build option:
//   DPRAM_WRITE_FIRST_EN defined   -> a same-cycle, same-address read on one
//                                     port and write on the other returns the
//                                     newly written word (write-first).
//   DPRAM_WRITE_FIRST_EN undefined -> that read returns the old contents
//                                     (read-first).
//
// The storage array is deliberately not reset; its contents survive rst_n.
module dual_port_ram_hs #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_port_ram_hs_if.slave  port_a,
    dual_port_ram_hs_if.slave  port_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rdy_q;
    logic                  rdy_d;
    logic [DATA_WIDTH-1:0] q_a_q;
    logic [DATA_WIDTH-1:0] q_a_d;
    logic [DATA_WIDTH-1:0] q_b_q;
    logic [DATA_WIDTH-1:0] q_b_d;

    logic                  same_addr;
    logic                  ww_collision;
    logic                  ready_b;
    logic                  acc_a;
    logic                  acc_b;
    logic                  wr_a;
    logic                  wr_b;
    logic                  rd_a;
    logic                  rd_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;

    // Handshake: decide which requests are accepted this cycle.
    always_comb begin
        same_addr    = (port_a.addr == port_b.addr);
        // Both ports writing the same word: A wins, B must wait a cycle.
        ww_collision = port_a.valid && port_a.we &&
                       port_b.valid && port_b.we && same_addr;
        ready_b      = rdy_q && !ww_collision;
        acc_a        = port_a.valid && rdy_q;
        acc_b        = port_b.valid && ready_b;
        wr_a         = acc_a && port_a.we;
        wr_b         = acc_b && port_b.we;
        rd_a         = acc_a && !port_a.we;
        rd_b         = acc_b && !port_b.we;
    end

    // Read path: select the word each port returns, with optional forwarding
    // of the other port's same-cycle write.
    always_comb begin
`ifdef DPRAM_WRITE_FIRST_EN
        rd_data_a = (wr_b && same_addr) ? port_b.data : mem[port_a.addr];
        rd_data_b = (wr_a && same_addr) ? port_a.data : mem[port_b.addr];
`else
        rd_data_a = mem[port_a.addr];
        rd_data_b = mem[port_b.addr];
`endif
    end

    // Next-state: read data only changes on an accepted read; ready rises
    // on the first edge out of reset and then stays high.
    always_comb begin
        rdy_d = 1'b1;
        q_a_d = q_a_q;
        q_b_d = q_b_q;
        if (rd_a) begin
            q_a_d = rd_data_a;
        end
        if (rd_b) begin
            q_b_d = rd_data_b;
        end
    end

    // Control and read-data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            rdy_q <= rdy_d;
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    // Storage writes. Acceptance is gated by rdy_q, which is held low in
    // reset, so no write lands while rst_n is asserted. Port A is applied
    // last; a same-address pair cannot both be accepted anyway.
    always_ff @(posedge clk) begin
        if (wr_b) begin
            mem[port_b.addr] <= port_b.data;
        end
        if (wr_a) begin
            mem[port_a.addr] <= port_a.data;
        end
    end

    assign port_a.ready = rdy_q;
    assign port_b.ready = ready_b;
    assign port_a.q     = q_a_q;
    assign port_b.q     = q_b_q;

endmodule

// File: tb/tb_dual_port_ram_hs.sv
// Directed testbench for dual_port_ram_hs. Works for either value of
// DPRAM_WRITE_FIRST_EN; the forwarding-dependent expectations follow it.
module tb_dual_port_ram_hs;
    localparam int DW = 8;
    localparam int AW = 6;

`ifdef DPRAM_WRITE_FIRST_EN
    localparam logic [DW-1:0] EXP_RW   = 8'h66;
    localparam logic [DW-1:0] EXP_COLL = 8'h22;
`else
    localparam logic [DW-1:0] EXP_RW   = 8'h55;
    localparam logic [DW-1:0] EXP_COLL = 8'h11;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    dual_port_ram_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
    dual_port_ram_hs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

    dual_port_ram_hs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .port_a (if_a.slave),
        .port_b (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if_a.valid = v; if_a.we = w; if_a.addr = ad; if_a.data = d;
    endtask

    task automatic set_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if_b.valid = v; if_b.we = w; if_b.addr = ad; if_b.data = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (if_a.q !== 8'h00) begin n_fail++; $display("FAIL reset_q_a cyc%0d: got %h want 00", i, if_a.q); end
            n_cmp++; if (if_b.q !== 8'h00) begin n_fail++; $display("FAIL reset_q_b cyc%0d: got %h want 00", i, if_b.q); end
            n_cmp++; if (if_a.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a cyc%0d: got %b want 0", i, if_a.ready); end
            n_cmp++; if (if_b.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b cyc%0d: got %b want 0", i, if_b.ready); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (if_a.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_a: got %b want 1", if_a.ready); end
        n_cmp++; if (if_b.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_b: got %b want 1", if_b.ready); end
    endtask

    task automatic test_port_a();
        @(negedge clk); set_a(1'b1, 1'b1, 6'h10, 8'hA5);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'h00) begin n_fail++; $display("FAIL a_q_on_write: got %h want 00", if_a.q); end
        @(negedge clk); set_a(1'b1, 1'b0, 6'h10, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'hA5) begin n_fail++; $display("FAIL a_read_10: got %h want a5", if_a.q); end
        // An invalid request must be ignored; q holds.
        @(negedge clk); set_a(1'b0, 1'b0, 6'h3F, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'hA5) begin n_fail++; $display("FAIL a_q_hold_invalid: got %h want a5", if_a.q); end
        @(negedge clk); idle();
    endtask

    task automatic test_cross_port();
        @(negedge clk); set_a(1'b1, 1'b1, 6'h3F, 8'h3C);
        @(negedge clk); set_a(1'b0, 1'b0, '0, '0); set_b(1'b1, 1'b0, 6'h3F, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_b.q !== 8'h3C) begin n_fail++; $display("FAIL b_read_3f: got %h want 3c", if_b.q); end
        @(negedge clk); set_b(1'b1, 1'b1, 6'h3F, 8'hC3);
        @(negedge clk); set_b(1'b0, 1'b0, '0, '0); set_a(1'b1, 1'b0, 6'h3F, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'hC3) begin n_fail++; $display("FAIL a_read_3f: got %h want c3", if_a.q); end
        n_cmp++; if (if_b.q !== 8'h3C) begin n_fail++; $display("FAIL b_q_hold_on_write: got %h want 3c", if_b.q); end
        @(negedge clk); idle();
    endtask

    task automatic test_collision();
        @(negedge clk); set_a(1'b1, 1'b1, 6'h05, 8'h11); set_b(1'b1, 1'b1, 6'h05, 8'h22);
        #1;
        n_cmp++; if (if_b.ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready_b: got %b want 0", if_b.ready); end
        n_cmp++; if (if_a.ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_a: got %b want 1", if_a.ready); end
        // B holds its write; A now reads the word A just wrote.
        @(negedge clk); set_a(1'b1, 1'b0, 6'h05, 8'h00);
        #1;
        n_cmp++; if (if_b.ready !== 1'b1) begin n_fail++; $display("FAIL coll_clear_ready_b: got %b want 1", if_b.ready); end
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== EXP_COLL) begin n_fail++; $display("FAIL coll_a_won: got %h want %h", if_a.q, EXP_COLL); end
        @(negedge clk); set_a(1'b0, 1'b0, '0, '0); set_b(1'b1, 1'b0, 6'h05, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_b.q !== 8'h22) begin n_fail++; $display("FAIL coll_b_later: got %h want 22", if_b.q); end
        @(negedge clk); idle();
    endtask

    task automatic test_read_write_same();
        @(negedge clk); set_a(1'b1, 1'b1, 6'h20, 8'h55);
        @(negedge clk); set_a(1'b1, 1'b1, 6'h20, 8'h66); set_b(1'b1, 1'b0, 6'h20, 8'h00);
        #1;
        n_cmp++; if (if_b.ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready_b: got %b want 1", if_b.ready); end
        @(posedge clk); #1;
        n_cmp++; if (if_b.q !== EXP_RW) begin n_fail++; $display("FAIL rw_same_b: got %h want %h", if_b.q, EXP_RW); end
        @(negedge clk); set_a(1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        n_cmp++; if (if_b.q !== 8'h66) begin n_fail++; $display("FAIL rw_after_b: got %h want 66", if_b.q); end
        @(negedge clk); idle();
    endtask

    task automatic test_dual_ops();
        // Different-address writes on both ports in one cycle.
        @(negedge clk); set_a(1'b1, 1'b1, 6'h01, 8'h9A); set_b(1'b1, 1'b1, 6'h02, 8'h6B);
        #1;
        n_cmp++; if (if_b.ready !== 1'b1) begin n_fail++; $display("FAIL diff_wr_ready_b: got %b want 1", if_b.ready); end
        @(negedge clk); set_a(1'b1, 1'b0, 6'h02, 8'h00); set_b(1'b1, 1'b0, 6'h01, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'h6B) begin n_fail++; $display("FAIL diff_wr_a_reads_02: got %h want 6b", if_a.q); end
        n_cmp++; if (if_b.q !== 8'h9A) begin n_fail++; $display("FAIL diff_wr_b_reads_01: got %h want 9a", if_b.q); end
        // Same-address reads on both ports.
        @(negedge clk); set_a(1'b1, 1'b0, 6'h10, 8'h00); set_b(1'b1, 1'b0, 6'h10, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'hA5) begin n_fail++; $display("FAIL rr_same_a: got %h want a5", if_a.q); end
        n_cmp++; if (if_b.q !== 8'hA5) begin n_fail++; $display("FAIL rr_same_b: got %h want a5", if_b.q); end
        @(negedge clk); idle();
    endtask

    task automatic test_async_reset();
        @(negedge clk); set_a(1'b1, 1'b0, 6'h01, 8'h00); set_b(1'b1, 1'b0, 6'h3F, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'h9A) begin n_fail++; $display("FAIL burst_a: got %h want 9a", if_a.q); end
        n_cmp++; if (if_b.q !== 8'hC3) begin n_fail++; $display("FAIL burst_b: got %h want c3", if_b.q); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if_a.q !== 8'h00) begin n_fail++; $display("FAIL async_q_a: got %h want 00", if_a.q); end
        n_cmp++; if (if_b.q !== 8'h00) begin n_fail++; $display("FAIL async_q_b: got %h want 00", if_b.q); end
        n_cmp++; if (if_a.ready !== 1'b0) begin n_fail++; $display("FAIL async_ready_a: got %b want 0", if_a.ready); end
        n_cmp++; if (if_b.ready !== 1'b0) begin n_fail++; $display("FAIL async_ready_b: got %b want 0", if_b.ready); end
        // Write requests presented while in reset must be dropped.
        @(negedge clk); set_a(1'b1, 1'b1, 6'h10, 8'hFF); set_b(1'b1, 1'b1, 6'h3F, 8'hEE);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'h00) begin n_fail++; $display("FAIL in_reset_q_a: got %h want 00", if_a.q); end
        @(negedge clk); idle(); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (if_a.ready !== 1'b1) begin n_fail++; $display("FAIL rerelease_ready_a: got %b want 1", if_a.ready); end
        @(negedge clk); set_a(1'b1, 1'b0, 6'h10, 8'h00); set_b(1'b1, 1'b0, 6'h3F, 8'h00);
        @(posedge clk); #1;
        n_cmp++; if (if_a.q !== 8'hA5) begin n_fail++; $display("FAIL persist_10: got %h want a5", if_a.q); end
        n_cmp++; if (if_b.q !== 8'hC3) begin n_fail++; $display("FAIL persist_3f: got %h want c3", if_b.q); end
        @(negedge clk); idle();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_port_a();
        test_cross_port();
        test_collision();
        test_read_write_same();
        test_dual_ops();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
